alu_regfile_datapath: RTL and testbench
=======================================

// Module: alu_regfile_datapath
// PURPOSE
//   Core datapath slice: a 16-entry x 16-bit register file (two async read
//   ports, one sync write port) and an independent 16-bit add/subtract ALU
//   with a zero flag. The register file feeds operand muxes in the top-level
//   datapath. The ALU takes its operands directly from ports SRCA/SRCB, so
//   both halves can be exercised and verified independently.
// PARAMETERS
//   DATA_W  16  datapath width (register and ALU word width)
//   ADDR_W  4   register address width; depth = 2**ADDR_W = 16 registers
// PORTS
//   CLOCK     in   1       single clock; all state updates on rising edge
//   RESET     in   1       synchronous, active-high reset
//   REGADDR1  in   ADDR_W  read address, port A
//   REGADDR2  in   ADDR_W  read address, port B
//   REGDEST   in   ADDR_W  write address
//   REGDATA   in   DATA_W  write data
//   REGWRITE  in   1       write enable (1 = write REGDATA to REGDEST at edge)
//   REGOUT_A  out  DATA_W  contents of register REGADDR1
//   REGOUT_B  out  DATA_W  contents of register REGADDR2
//   SRCA      in   DATA_W  ALU operand A
//   SRCB      in   DATA_W  ALU operand B
//   ALUOP     in   1       0 = ADD, 1 = SUB
//   ALUOUT    out  DATA_W  ALU result
//   ZERO      out  1       1 when ALUOUT == 0
// BEHAVIOUR
//   Register file:
//   - On the rising CLOCK edge with RESET=1, all 16 registers clear to 0x0000.
//     RESET has priority over REGWRITE in the same cycle.
//   - On the rising CLOCK edge with RESET=0 and REGWRITE=1, reg[REGDEST] is
//     loaded with REGDATA. When REGWRITE=0, no register changes.
//   - All 16 registers, including reg 0, are ordinary and writable.
//   - Reads are combinational: REGOUT_A = reg[REGADDR1] and
//     REGOUT_B = reg[REGADDR2], with zero-cycle latency from an address change.
//   - No write-to-read bypass: a read of REGDEST in the write cycle returns
//     the old value. The new value appears after the edge.
//   - Both read ports may address the same register; both return its value.
//   - After reset, every REGOUT reads 0x0000 until the register is written.
//   ALU (purely combinational, no state, unaffected by RESET):
//   - ALUOP=0: ALUOUT = (SRCA + SRCB) mod 2**16.
//   - ALUOP=1: ALUOUT = (SRCA - SRCB) mod 2**16, two's complement.
//   - Carry and overflow are discarded; there are no carry/overflow outputs.
//   - ZERO = (ALUOUT == 0), evaluated combinationally on the result.
//   - Outputs are settled within the same cycle; latency 0.
//   X-free: no output may be X after the first reset edge, for any input.
// STRUCTURE
//   Shared package riscblade_pkg:
//   - DATA_W and ADDR_W constants.
//   - ALU op encodings ALU_ADD=1'b0, ALU_SUB=1'b1.
//   One sub-module, reg_file_16x16:
//   - Storage array, sync reset, write port, two async read muxes.
//   The ALU is a single combinational always block in the top module.
// TESTING
//   1 Reset, then read all 16 addresses on both ports -> every read = 0x0000.
//   2 Write reg3=0x1234, reg7=0xBEEF; REGADDR1=3, REGADDR2=7
//     -> REGOUT_A=0x1234, REGOUT_B=0xBEEF.
//   3 Write reg5=0xAAAA, REGADDR1=5 in the same cycle
//     -> REGOUT_A holds the old value before the edge, 0xAAAA after it.
//     REGWRITE=0 with REGDATA=0xFFFF -> reg5 remains 0xAAAA.
//   4 RESET=1 and REGWRITE=1 (reg2<=0x5555) in the same cycle
//     -> reg2 reads 0x0000 after the edge.
//   5 ALUOP=0, SRCA=0x0005, SRCB=0x0003 -> ALUOUT=0x0008, ZERO=0.
//     ALUOP=0, SRCA=0xFFFF, SRCB=0x0001 -> ALUOUT=0x0000, ZERO=1 (wrap).
//   6 ALUOP=1, SRCA=0x0007, SRCB=0x0007 -> ALUOUT=0x0000, ZERO=1.
//     ALUOP=1, SRCA=0x0003, SRCB=0x0005 -> ALUOUT=0xFFFE, ZERO=0.

Source files
------------

// File: rtl/riscblade_pkg.sv
// Shared constants and ALU op encodings for the riscblade datapath slice.
package riscblade_pkg;

   localparam int DATA_W    = 16;
   localparam int ADDR_W    = 4;
   localparam int REG_DEPTH = 1 << ADDR_W;

   typedef enum logic {
      ALU_ADD = 1'b0,
      ALU_SUB = 1'b1
   } alu_op_e;

endpackage : riscblade_pkg

// File: rtl/reg_file_16x16.sv
// 16 x 16-bit register file: sync reset, one sync write port,
// two combinational read ports with no write-to-read bypass.
module reg_file_16x16
   import riscblade_pkg::*;
(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic [ADDR_W-1:0] i_regaddr1,
   input  logic [ADDR_W-1:0] i_regaddr2,
   input  logic [ADDR_W-1:0] i_regdest,
   input  logic [DATA_W-1:0] i_regdata,
   input  logic              i_regwrite,
   output logic [DATA_W-1:0] o_regout_a,
   output logic [DATA_W-1:0] o_regout_b
);

   logic [DATA_W-1:0] r_regs [REG_DEPTH];

   // Storage update: reset clears every entry, otherwise write one entry.
   // NOTE: the array is cleared on reset because every read must return 0x0000
   // (never X) after reset; this rules out a reset-less RAM macro.
   // NOTE: non-blocking assignments so reads in this cycle still see old data.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < REG_DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_regwrite) begin
         r_regs[i_regdest] <= i_regdata;
      end
   end

   // Read muxes are purely combinational: zero-cycle latency, old value
   // visible during a write cycle.
   assign o_regout_a = r_regs[i_regaddr1];
   assign o_regout_b = r_regs[i_regaddr2];

endmodule : reg_file_16x16

// File: rtl/alu_regfile_datapath.sv
// Datapath slice: register file plus an independent 16-bit add/sub ALU
// with a zero flag. ALU operands come straight from ports.
module alu_regfile_datapath
   import riscblade_pkg::*;
(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic [ADDR_W-1:0] i_regaddr1,
   input  logic [ADDR_W-1:0] i_regaddr2,
   input  logic [ADDR_W-1:0] i_regdest,
   input  logic [DATA_W-1:0] i_regdata,
   input  logic              i_regwrite,
   output logic [DATA_W-1:0] o_regout_a,
   output logic [DATA_W-1:0] o_regout_b,
   input  logic [DATA_W-1:0] i_srca,
   input  logic [DATA_W-1:0] i_srcb,
   input  logic              i_aluop,
   output logic [DATA_W-1:0] o_aluout,
   output logic              o_zero
);

   logic [DATA_W-1:0] w_alu_result;
   alu_op_e           w_alu_op;

   reg_file_16x16 u_reg_file (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_regaddr1 (i_regaddr1),
      .i_regaddr2 (i_regaddr2),
      .i_regdest  (i_regdest),
      .i_regdata  (i_regdata),
      .i_regwrite (i_regwrite),
      .o_regout_a (o_regout_a),
      .o_regout_b (o_regout_b)
   );

   assign w_alu_op = alu_op_e'(i_aluop);

   // ALU: add or subtract modulo 2**DATA_W; carry/borrow is dropped.
   // NOTE: default assignment first so no path leaves the result unassigned
   // (which would infer a latch).
   always_comb begin
      w_alu_result = '0;
      case (w_alu_op)
         ALU_ADD: w_alu_result = i_srca + i_srcb;
         ALU_SUB: w_alu_result = i_srca - i_srcb;
         default: w_alu_result = '0;
      endcase
   end

   assign o_aluout = w_alu_result;
   assign o_zero   = (w_alu_result == '0);

endmodule : alu_regfile_datapath

// File: tb/tb_alu_regfile_datapath.sv
// Self-checking bench: directed cases plus randomized register-file traffic
// and ALU operands, compared against a plain array / arithmetic model.
module tb_alu_regfile_datapath;

   logic        clk;
   logic        reset;
   logic [3:0]  regaddr1, regaddr2, regdest;
   logic [15:0] regdata;
   logic        regwrite;
   logic [15:0] regout_a, regout_b;
   logic [15:0] srca, srcb;
   logic        aluop;
   logic [15:0] aluout;
   logic        zero;

   int          n_checks;
   int          n_errors;
   int unsigned model_regs [16];

   alu_regfile_datapath dut (
      .i_clock    (clk),
      .i_reset    (reset),
      .i_regaddr1 (regaddr1),
      .i_regaddr2 (regaddr2),
      .i_regdest  (regdest),
      .i_regdata  (regdata),
      .i_regwrite (regwrite),
      .o_regout_a (regout_a),
      .o_regout_b (regout_b),
      .i_srca     (srca),
      .i_srcb     (srcb),
      .i_aluop    (aluop),
      .o_aluout   (aluout),
      .o_zero     (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Model update for one clock edge with current inputs.
   task automatic model_edge();
      if (reset) begin
         for (int i = 0; i < 16; i++) model_regs[i] = 0;
      end else if (regwrite) begin
         model_regs[regdest] = regdata;
      end
   endtask

   // Apply one rising edge and let outputs settle afterwards.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_reads(input string tag);
      check({tag, "_a"}, {16'h0, regout_a}, model_regs[regaddr1]);
      check({tag, "_b"}, {16'h0, regout_b}, model_regs[regaddr2]);
   endtask

   task automatic check_alu(input string tag);
      int unsigned exp_res;
      if (aluop == 1'b0) exp_res = (int'(srca) + int'(srcb)) % 65536;
      else               exp_res = (int'(srca) - int'(srcb) + 65536) % 65536;
      #1;
      check({tag, "_out"}, {16'h0, aluout}, exp_res);
      check({tag, "_zero"}, {31'h0, zero}, (exp_res == 0) ? 1 : 0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < 16; i++) model_regs[i] = 0;
      reset = 1'b1; regwrite = 1'b0; regdest = '0; regdata = '0;
      regaddr1 = '0; regaddr2 = '0; srca = '0; srcb = '0; aluop = 1'b0;

      // 1: reset, every address reads zero on both ports
      tick();
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         regaddr1 = 4'(i); regaddr2 = 4'(15 - i);
         #1;
         check("rst_rd_a", {16'h0, regout_a}, 32'h0);
         check("rst_rd_b", {16'h0, regout_b}, 32'h0);
      end

      // 2: two writes then read both
      @(negedge clk);
      regwrite = 1'b1; regdest = 4'd3; regdata = 16'h1234;
      tick();
      @(negedge clk);
      regdest = 4'd7; regdata = 16'hBEEF;
      tick();
      @(negedge clk);
      regwrite = 1'b0; regaddr1 = 4'd3; regaddr2 = 4'd7;
      #1;
      check("wr3_rd", {16'h0, regout_a}, 32'h1234);
      check("wr7_rd", {16'h0, regout_b}, 32'hBEEF);

      // 3: no bypass; old value before edge, new after; disabled write ignored
      @(negedge clk);
      regwrite = 1'b1; regdest = 4'd5; regdata = 16'hAAAA; regaddr1 = 4'd5; regaddr2 = 4'd5;
      #1;
      check("nobypass_pre", {16'h0, regout_a}, 32'h0);
      tick();
      check("nobypass_post_a", {16'h0, regout_a}, 32'hAAAA);
      check("nobypass_post_b", {16'h0, regout_b}, 32'hAAAA);
      @(negedge clk);
      regwrite = 1'b0; regdata = 16'hFFFF;
      tick();
      check("we0_hold", {16'h0, regout_a}, 32'hAAAA);

      // 4: reset beats write in the same cycle
      @(negedge clk);
      reset = 1'b1; regwrite = 1'b1; regdest = 4'd2; regdata = 16'h5555;
      regaddr1 = 4'd2; regaddr2 = 4'd3;
      tick();
      check("rst_prio_r2", {16'h0, regout_a}, 32'h0);
      check("rst_prio_r3", {16'h0, regout_b}, 32'h0);
      @(negedge clk);
      reset = 1'b0; regwrite = 1'b0;

      // 5/6: directed ALU corners
      aluop = 1'b0; srca = 16'h0005; srcb = 16'h0003;
      #1; check("add_5_3", {16'h0, aluout}, 32'h0008); check("add_5_3_z", {31'h0, zero}, 32'h0);
      srca = 16'hFFFF; srcb = 16'h0001;
      #1; check("add_wrap", {16'h0, aluout}, 32'h0000); check("add_wrap_z", {31'h0, zero}, 32'h1);
      aluop = 1'b1; srca = 16'h0007; srcb = 16'h0007;
      #1; check("sub_eq", {16'h0, aluout}, 32'h0000); check("sub_eq_z", {31'h0, zero}, 32'h1);
      srca = 16'h0003; srcb = 16'h0005;
      #1; check("sub_neg", {16'h0, aluout}, 32'hFFFE); check("sub_neg_z", {31'h0, zero}, 32'h0);

      // Random register-file traffic with an occasional reset.
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         reset    = ($urandom_range(0, 31) == 0);
         regwrite = $urandom_range(0, 1);
         regdest  = 4'($urandom);
         regdata  = 16'($urandom);
         regaddr1 = ($urandom_range(0, 3) == 0) ? regdest : 4'($urandom);
         regaddr2 = ($urandom_range(0, 3) == 0) ? regaddr1 : 4'($urandom);
         #1;
         check_reads("rnd_pre");
         tick();
         check_reads("rnd_post");
      end
      reset = 1'b0; regwrite = 1'b0;

      // Random ALU operands, biased toward equal operands and wrap cases.
      for (int n = 0; n < 300; n++) begin
         aluop = $urandom_range(0, 1);
         srca  = 16'($urandom);
         case ($urandom_range(0, 3))
            0: srcb = srca;
            1: srcb = 16'(16'h0 - srca);
            default: srcb = 16'($urandom);
         endcase
         check_alu("rnd_alu");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule : tb_alu_regfile_datapath
